// File: rtl/output_cdf_table_writer.sv
// Streams histogram counts from memory, accumulates a saturating prefix sum and writes
// each CDF entry back to memory, reporting the first non-zero CDF value and overflow.
module output_cdf_table_writer #(
    parameter int              NUM_BINS  = 256,
    parameter int              CNT_W     = 20,
    parameter int              BUS_W     = 128,
    parameter int              ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] HIST_BASE = 16'h0100,
    parameter logic [ADDR_W-1:0] CDF_BASE  = 16'h0000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              StartIn,
    output logic              Busy,
    output logic              DoneOut,
    output logic [ADDR_W-1:0] HistReadAddress,
    input  logic [BUS_W-1:0]  HistReadBus,
    output logic [ADDR_W-1:0] WriteAddress,
    output logic [BUS_W-1:0]  WriteBus,
    output logic              WriteEnable,
    output logic [CNT_W-1:0]  CdfMin,
    output logic              Overflow
);
    localparam int IDX_W = $clog2(NUM_BINS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  rd_idx_q;
    logic              rd_valid_q;
    logic [IDX_W-1:0]  rd_bin_q;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [BUS_W-1:0]  wbus_q;
    logic              done_q;
    logic [CNT_W-1:0]  cdfmin_q;
    logic              min_found_q;
    logic              ovf_q;
    logic [CNT_W:0]    sum;
    logic              sat;
    logic              start_ok;
    logic              last_idx;
    logic              unused_hist_hi;

    // The DoneOut cycle is already IDLE, so a start there must be masked explicitly.
    assign start_ok = StartIn && (state_q == S_IDLE) && !done_q;
    assign last_idx = (rd_idx_q == IDX_W'(NUM_BINS - 1));

    assign sum   = {1'b0, acc_q} + {1'b0, HistReadBus[CNT_W-1:0]};
    assign sat   = sum[CNT_W];
    assign acc_d = sat ? {CNT_W{1'b1}} : sum[CNT_W-1:0];

    assign unused_hist_hi = ^HistReadBus[BUS_W-1:CNT_W];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = S_READ;
            S_READ:  if (last_idx) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            rd_idx_q    <= '0;
            rd_valid_q  <= 1'b0;
            rd_bin_q    <= '0;
            acc_q       <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wbus_q      <= '0;
            done_q      <= 1'b0;
            cdfmin_q    <= '0;
            min_found_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= 1'b0;
            done_q     <= (state_q == S_DONE);
            rd_valid_q <= (state_q == S_READ);
            rd_bin_q   <= rd_idx_q;

            if (state_q == S_READ) rd_idx_q <= rd_idx_q + 1'b1;

            if (start_ok) begin
                rd_idx_q    <= '0;
                acc_q       <= '0;
                cdfmin_q    <= '0;
                min_found_q <= 1'b0;
                ovf_q       <= 1'b0;
            end

            // Read data for rd_bin_q is on the bus this cycle.
            if (rd_valid_q) begin
                acc_q   <= acc_d;
                we_q    <= 1'b1;
                waddr_q <= CDF_BASE + ADDR_W'(rd_bin_q);
                wbus_q  <= BUS_W'(acc_d);
                if (sat) ovf_q <= 1'b1;
                if (!min_found_q && (acc_d != '0)) begin
                    cdfmin_q    <= acc_d;
                    min_found_q <= 1'b1;
                end
            end
        end
    end

    assign HistReadAddress = (state_q == S_READ) ? HIST_BASE + ADDR_W'(rd_idx_q) : HIST_BASE;
    assign Busy            = (state_q != S_IDLE);
    assign DoneOut         = done_q;
    assign WriteEnable     = we_q;
    assign WriteAddress    = waddr_q;
    assign WriteBus        = wbus_q;
    assign CdfMin          = cdfmin_q;
    assign Overflow        = ovf_q;

endmodule
